// File: rtl/buffer_drain_pkg.sv
// rtl/buffer_drain_pkg.sv - shared types and helpers for the buffer drain arbiter
package buffer_drain_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // Bytes held by a buffer, derived from its free-space count.
    function automatic int unsigned occupancy(input int unsigned avai, input int unsigned size);
        return size - avai;
    endfunction

endpackage

// File: rtl/buffer_drain_arbiter_rr_priority_picker.sv
// rtl/buffer_drain_arbiter_rr_priority_picker.sv - round-robin search for the next requesting buffer
module rr_priority_picker
    import buffer_drain_pkg::*;
#(
    parameter int NUM_BUF = 4,
    parameter int IDX_W   = $clog2(NUM_BUF)
) (
    input  logic [NUM_BUF-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any_req,
    output logic [IDX_W-1:0]   next_idx
);

    // Walk offsets from far to near so the nearest requester after last_grant wins.
    always_comb begin
        any_req  = |req;
        next_idx = '0;
        for (int k = NUM_BUF; k >= 1; k--) begin
            if (req[(int'(last_grant) + k) % NUM_BUF]) begin
                next_idx = IDX_W'((int'(last_grant) + k) % NUM_BUF);
            end
        end
    end

endmodule

// File: rtl/buffer_drain_arbiter.sv
// rtl/buffer_drain_arbiter.sv - round-robin drain of NUM_BUF byte buffers into one valid/ready sink
module buffer_drain_arbiter
    import buffer_drain_pkg::*;
#(
    parameter int NUM_BUF          = 4,
    parameter int BUFFER_BYTE_SIZE = 4,
    parameter int AVAI_W           = $clog2(BUFFER_BYTE_SIZE) + 1,
    parameter int BURST_LEN        = 4,
    parameter int IDX_W            = $clog2(NUM_BUF)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_BUF*AVAI_W-1:0] buf_avai,
    input  logic [NUM_BUF*8-1:0]      buf_data,
    output logic [NUM_BUF-1:0]        buf_output_en,
    output logic                      sink_valid,
    output logic [7:0]                sink_data,
    input  logic                      sink_ready,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      busy
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   last_grant;
    logic [CNT_W-1:0]   burst_cnt;
    logic [NUM_BUF-1:0] non_empty;
    logic               any_req;
    logic [IDX_W-1:0]   pick_idx;
    logic [AVAI_W-1:0]  grant_avai;
    logic [AVAI_W-1:0]  grant_occ;
    logic [7:0]         grant_data;
    logic               xfer;
    logic               burst_done;
    logic               last_byte;
    logic               end_grant;

    always_comb begin
        non_empty = '0;
        for (int i = 0; i < NUM_BUF; i++) begin
            non_empty[i] = buf_avai[i*AVAI_W +: AVAI_W] != AVAI_W'(BUFFER_BYTE_SIZE);
        end
    end

    always_comb begin
        grant_avai = AVAI_W'(BUFFER_BYTE_SIZE);
        grant_data = '0;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (IDX_W'(i) == grant_idx) begin
                grant_avai = buf_avai[i*AVAI_W +: AVAI_W];
                grant_data = buf_data[i*8 +: 8];
            end
        end
    end

    assign grant_occ = AVAI_W'(occupancy(32'(grant_avai), BUFFER_BYTE_SIZE));

    rr_priority_picker #(
        .NUM_BUF (NUM_BUF),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (non_empty),
        .last_grant (last_grant),
        .any_req    (any_req),
        .next_idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Last-byte test uses the count seen this cycle; a same-cycle push cannot extend the grant.
    assign xfer       = sink_valid & sink_ready;
    assign last_byte  = grant_occ == AVAI_W'(1);
    assign burst_done = burst_cnt == CNT_W'(BURST_LEN - 1);
    assign end_grant  = xfer ? (burst_done | last_byte) : !sink_valid;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req)   state_next = SERVE;
            SERVE:   if (end_grant) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reset masks the strobes combinationally so a reset mid-burst never pops a byte.
    always_comb begin
        sink_valid    = 1'b0;
        sink_data     = '0;
        buf_output_en = '0;
        busy          = 1'b0;
        if (!reset && state == SERVE) begin
            busy                     = 1'b1;
            sink_valid               = grant_avai != AVAI_W'(BUFFER_BYTE_SIZE);
            sink_data                = grant_data;
            buf_output_en[grant_idx] = sink_valid & sink_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IDX_W'(NUM_BUF - 1);
            grant_idx  <= '0;
            burst_cnt  <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                grant_idx <= pick_idx;
                burst_cnt <= '0;
            end
        end else begin
            if (end_grant) begin
                last_grant <= grant_idx;
            end else if (xfer) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_buffer_drain_arbiter.sv
// tb/tb_buffer_drain_arbiter.sv - self-checking bench for buffer_drain_arbiter
module tb_buffer_drain_arbiter;

    localparam int NB   = 4;
    localparam int SIZE = 4;
    localparam int AW   = 3;
    localparam int IW   = 2;
    localparam int BL_A = 4;
    localparam int BL_B = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NB*AW-1:0] avai_v;
    logic [NB*8-1:0]  data_v;
    logic            ready_v;

    logic [NB-1:0] a_en, b_en;
    logic          a_valid, b_valid, a_busy, b_busy;
    logic [7:0]    a_data, b_data;
    logic [IW-1:0] a_grant, b_grant;

    always #5 clk = ~clk;

    buffer_drain_arbiter #(.NUM_BUF(NB), .BUFFER_BYTE_SIZE(SIZE), .BURST_LEN(BL_A)) dut_a (
        .clk(clk), .reset(reset), .buf_avai(avai_v), .buf_data(data_v),
        .buf_output_en(a_en), .sink_valid(a_valid), .sink_data(a_data),
        .sink_ready(ready_v), .grant_idx(a_grant), .busy(a_busy)
    );

    buffer_drain_arbiter #(.NUM_BUF(NB), .BUFFER_BYTE_SIZE(SIZE), .BURST_LEN(BL_B)) dut_b (
        .clk(clk), .reset(reset), .buf_avai(avai_v), .buf_data(data_v),
        .buf_output_en(b_en), .sink_valid(b_valid), .sink_data(b_data),
        .sink_ready(ready_v), .grant_idx(b_grant), .busy(b_busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model of dut_a: who owns the sink, bytes served this grant, last owner.
    int            m_owner  = -1;
    int            m_served = 0;
    int            m_last   = NB - 1;
    int            m_grant  = 0;
    logic [NB-1:0] m_en     = '0;

    logic [7:0]    q[NB][$];
    logic          use_q     = 1'b1;
    logic [NB-1:0] topup     = '0;
    logic          rand_push = 1'b0;

    typedef struct {
        logic [NB*AW-1:0] avai;
        logic [NB*8-1:0]  data;
        logic             ready;
        logic             e_valid;
        logic [NB-1:0]    e_en;
        logic [IW-1:0]    e_grant;
        logic             e_busy;
        logic [7:0]       e_data;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NB*AW-1:0] mk_avai(input int a0, input int a1, input int a2, input int a3);
        logic [NB*AW-1:0] r;
        r = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < NB; i++) begin
            avai_v[i*AW +: AW] = AW'(SIZE - q[i].size());
            data_v[i*8 +: 8]   = (q[i].size() > 0) ? q[i][0] : 8'h00;
        end
    endtask

    task automatic sample();
        int            a[NB];
        int            occ;
        int            j;
        logic          found;
        logic          e_valid;
        logic [NB-1:0] e_en;
        logic [7:0]    e_data;
        logic          e_busy;
        @(negedge clk);
        for (int i = 0; i < NB; i++) a[i] = int'(avai_v[i*AW +: AW]);
        e_valid = 1'b0; e_en = '0; e_data = '0; e_busy = 1'b0; occ = 0;
        if (!reset && m_owner >= 0) begin
            occ     = SIZE - a[m_owner];
            e_valid = occ != 0;
            e_data  = data_v[m_owner*8 +: 8];
            e_busy  = 1'b1;
            if (e_valid && ready_v) e_en = NB'(1 << m_owner);
        end
        chk("model_valid", 32'(a_valid), 32'(e_valid));
        chk("model_en", 32'(a_en), 32'(e_en));
        chk("model_data", 32'(a_data), 32'(e_data));
        chk("model_busy", 32'(a_busy), 32'(e_busy));
        if (!reset) chk("model_grant", 32'(a_grant), 32'(m_grant));
        m_en = e_en;
        if (reset) begin
            m_owner = -1; m_last = NB - 1; m_grant = 0; m_served = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= NB; k++) begin
                j = (m_last + k) % NB;
                if (!found && a[j] != SIZE) begin
                    found = 1'b1; m_owner = j; m_grant = j; m_served = 0;
                end
            end
        end else if (e_valid && ready_v) begin
            m_served++;
            if (m_served == BL_A || occ == 1) begin
                m_last = m_owner; m_owner = -1;
            end
        end else if (!e_valid) begin
            m_last = m_owner; m_owner = -1;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (use_q) begin
            for (int i = 0; i < NB; i++) if (m_en[i] && q[i].size() > 0) void'(q[i].pop_front());
            for (int i = 0; i < NB; i++) if (topup[i]) while (q[i].size() < SIZE) q[i].push_back(8'($urandom));
            if (rand_push)
                for (int i = 0; i < NB; i++)
                    if (q[i].size() < SIZE && $urandom_range(0, 2) == 0) q[i].push_back(8'($urandom));
            drive();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; ready_v = 1'b1; use_q = 1'b1; topup = '0; rand_push = 1'b0;
        for (int i = 0; i < NB; i++) q[i].delete();
        drive();
        sample();
        advance();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic          ev[9];
        int            eg[9];
        logic          rv;
        int            g;
        tbl[0] = '{mk_avai(4, 4, 1, 4), 32'h0011_0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00};
        tbl[1] = '{mk_avai(4, 4, 1, 4), 32'h0011_0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h11};
        tbl[2] = '{mk_avai(4, 4, 2, 4), 32'h0022_0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h22};
        tbl[3] = '{mk_avai(4, 4, 3, 4), 32'h0033_0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h33};
        tbl[4] = '{mk_avai(4, 4, 4, 4), 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0, 8'h00};
        tbl[5] = '{mk_avai(4, 4, 4, 4), 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0, 8'h00};

        // Reset state
        do_reset();
        sample();
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_en", 32'(a_en), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_grant", 32'(a_grant), 32'd0);
        advance();

        // Single buffer, table driven
        use_q = 1'b0;
        for (int r = 0; r < 6; r++) begin
            avai_v = tbl[r].avai; data_v = tbl[r].data; ready_v = tbl[r].ready;
            sample();
            chk($sformatf("tbl%0d_valid", r), 32'(a_valid), 32'(tbl[r].e_valid));
            chk($sformatf("tbl%0d_en", r), 32'(a_en), 32'(tbl[r].e_en));
            chk($sformatf("tbl%0d_grant", r), 32'(a_grant), 32'(tbl[r].e_grant));
            chk($sformatf("tbl%0d_busy", r), 32'(a_busy), 32'(tbl[r].e_busy));
            chk($sformatf("tbl%0d_data", r), 32'(a_data), 32'(tbl[r].e_data));
            advance();
        end
        use_q = 1'b1;

        // Round robin on the BURST_LEN=2 instance, all buffers kept full
        do_reset();
        for (int i = 0; i < NB; i++) while (q[i].size() < SIZE) q[i].push_back(8'(16 * i + q[i].size()));
        topup = 4'hF;
        drive();
        for (int k = 0; k < 15; k++) begin
            rv = (k % 3) != 0;
            g  = (k / 3) % NB;
            sample();
            chk($sformatf("rr%0d_valid", k), 32'(b_valid), 32'(rv));
            chk($sformatf("rr%0d_busy", k), 32'(b_busy), 32'(rv));
            chk($sformatf("rr%0d_en", k), 32'(b_en), rv ? 32'(1 << g) : 32'd0);
            if (rv) begin
                chk($sformatf("rr%0d_grant", k), 32'(b_grant), 32'(g));
                chk($sformatf("rr%0d_data", k), 32'(b_data), 32'(data_v[g*8 +: 8]));
            end
            advance();
        end

        // Backpressure on buffer 1
        do_reset();
        q[1].push_back(8'hA5); q[1].push_back(8'h5A);
        ready_v = 1'b0;
        drive();
        sample();
        chk("bp_idle_valid", 32'(a_valid), 32'd0);
        advance();
        for (int c = 1; c <= 5; c++) begin
            sample();
            chk($sformatf("bp%0d_valid", c), 32'(a_valid), 32'd1);
            chk($sformatf("bp%0d_en", c), 32'(a_en), 32'd0);
            chk($sformatf("bp%0d_data", c), 32'(a_data), 32'hA5);
            chk($sformatf("bp%0d_grant", c), 32'(a_grant), 32'd1);
            advance();
        end
        ready_v = 1'b1;
        sample();
        chk("bp_pop_en", 32'(a_en), 32'b0010);
        advance();
        ready_v = 1'b0;
        sample();
        chk("bp_after_en", 32'(a_en), 32'd0);
        chk("bp_after_data", 32'(a_data), 32'h5A);
        advance();
        ready_v = 1'b1;
        sample();
        chk("bp_last_en", 32'(a_en), 32'b0010);
        advance();
        sample();
        chk("bp_end_busy", 32'(a_busy), 32'd0);
        advance();

        // Burst cap with refill: buffer 0 topped up, buffer 3 holds one byte
        do_reset();
        for (int i = 0; i < SIZE; i++) q[0].push_back(8'(i));
        q[3].push_back(8'h3C);
        topup = 4'b0001;
        drive();
        ev = '{0, 1, 1, 1, 1, 0, 1, 0, 1};
        eg = '{0, 0, 0, 0, 0, 0, 3, 0, 0};
        for (int k = 0; k < 9; k++) begin
            sample();
            chk($sformatf("cap%0d_valid", k), 32'(a_valid), 32'(ev[k]));
            chk($sformatf("cap%0d_en", k), 32'(a_en), ev[k] ? 32'(1 << eg[k]) : 32'd0);
            if (ev[k]) chk($sformatf("cap%0d_grant", k), 32'(a_grant), 32'(eg[k]));
            if (k == 6) chk("cap_byte", 32'(a_data), 32'h3C);
            advance();
        end

        // Reset during the second transfer of a burst
        do_reset();
        for (int i = 0; i < SIZE; i++) q[0].push_back(8'(i));
        q[1].push_back(8'h77); q[1].push_back(8'h78);
        topup = 4'b0001;
        drive();
        sample();
        advance();
        sample();
        chk("mid_first_en", 32'(a_en), 32'b0001);
        advance();
        reset = 1'b1;
        sample();
        chk("mid_rst_en", 32'(a_en), 32'd0);
        chk("mid_rst_valid", 32'(a_valid), 32'd0);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_data", 32'(a_data), 32'd0);
        advance();
        reset = 1'b0;
        sample();
        chk("mid_idle_busy", 32'(a_busy), 32'd0);
        chk("mid_idle_grant", 32'(a_grant), 32'd0);
        chk("mid_idle_en", 32'(a_en), 32'd0);
        advance();
        sample();
        chk("mid_regrant_grant", 32'(a_grant), 32'd0);
        chk("mid_regrant_valid", 32'(a_valid), 32'd1);
        advance();

        // Random traffic against the model
        do_reset();
        rand_push = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            ready_v = $urandom_range(0, 3) != 0;
            reset   = $urandom_range(0, 199) == 0;
            sample();
            advance();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
